// File: rtl/sram_stream_reader.sv
// sram_stream_reader: read-side client of sram_top. On start it reads len
// consecutive words from base_addr and streams them out on a valid/ready
// master port. A 2-entry buffer absorbs the 1-cycle SRAM read latency, so a
// continuously-ready sink receives one word per cycle.
// Optional feature macro: SRAM_RD_STRIDE_EN adds a stride input that sets the
// address step (default build steps by 1).
module sram_stream_reader #(
  parameter int DW = 64,
  parameter int MW = 8,
  parameter int AW = 14,
  parameter int LW = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [LW-1:0] len,
`ifdef SRAM_RD_STRIDE_EN
  input  logic [AW-1:0] stride,
`endif
  output logic          busy,
  output logic          done,
  output logic          sram_cs,
  output logic          sram_we,
  output logic [MW-1:0] sram_wem,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_din,
  input  logic [DW-1:0] sram_dout,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  input  logic          m_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q;
  logic [AW-1:0]   step;
  logic [LW-1:0]   remaining;
  logic            inflight;
  logic            inflight_last;
  logic            done_q;

  // Two-entry buffer; entry 0 is always the head presented on the stream.
  logic [DW-1:0]   buf0_data, buf1_data;
  logic            buf0_last, buf1_last;
  logic [1:0]      buf_cnt;

  logic            start_ok;
  logic            pop;
  logic            push;
  logic            issue;
  logic            issue_last;
  logic [2:0]      occupancy;

`ifdef SRAM_RD_STRIDE_EN
  logic [AW-1:0]   stride_q;

  // Stride is captured with the transfer so it cannot change mid-stream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stride_q <= '0;
    end else if (start_ok) begin
      stride_q <= stride;
    end
  end

  assign step = stride_q;
`else
  assign step = {{(AW-1){1'b0}}, 1'b1};
`endif

  // Read-only client: write side of the SRAM port is held inactive.
  assign sram_we   = 1'b0;
  assign sram_wem  = '0;
  assign sram_din  = '0;
  assign sram_cs   = issue;
  assign sram_addr = addr_q;

  assign m_valid   = (buf_cnt != 2'd0);
  assign m_data    = buf0_data;
  assign m_last    = buf0_last;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

  // Issue/handshake decode: a read may issue only if the word it returns
  // still fits once this cycle's pop (if any) has freed its slot.
  always_comb begin
    start_ok   = (state_q == IDLE) && start;
    pop        = m_valid && m_ready;
    push       = inflight;
    occupancy  = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
    issue      = (state_q == RUN) && (remaining != '0) && (occupancy < 3'd2);
    issue_last = issue && (remaining == {{(LW-1){1'b0}}, 1'b1});
  end

  // FSM next-state: RUN until the final read issues, DRAIN until the final
  // word is accepted downstream.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start && (len != '0)) state_d = RUN;
      end
      RUN: begin
        if (issue_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop && buf0_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Address and length counters; address wraps naturally at 2^AW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      remaining <= '0;
    end else if (start_ok) begin
      addr_q    <= base_addr;
      remaining <= len;
    end else if (issue) begin
      addr_q    <= addr_q + step;
      remaining <= remaining - {{(LW-1){1'b0}}, 1'b1};
    end
  end

  // In-flight tracker: marks that sram_dout carries a word this cycle, and
  // whether that word ends the transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_last <= issue_last;
    end
  end

  // Completion pulse: zero-length start, or handshake of the last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
    end else begin
      done_q <= (start_ok && (len == '0)) ||
                ((state_q == DRAIN) && pop && buf0_last);
    end
  end

  // Output buffer: shift on pop, append returning SRAM word on push; both may
  // happen in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf0_data <= '0;
      buf1_data <= '0;
      buf0_last <= 1'b0;
      buf1_last <= 1'b0;
      buf_cnt   <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (buf_cnt == 2'd0) begin
            buf0_data <= sram_dout;
            buf0_last <= inflight_last;
          end else begin
            buf1_data <= sram_dout;
            buf1_last <= inflight_last;
          end
          buf_cnt <= buf_cnt + 2'd1;
        end
        2'b01: begin
          buf0_data <= buf1_data;
          buf0_last <= buf1_last;
          buf_cnt   <= buf_cnt - 2'd1;
        end
        2'b11: begin
          if (buf_cnt == 2'd1) begin
            buf0_data <= sram_dout;
            buf0_last <= inflight_last;
          end else begin
            buf0_data <= buf1_data;
            buf0_last <= buf1_last;
            buf1_data <= sram_dout;
            buf1_last <= inflight_last;
          end
        end
        default: begin
          buf_cnt <= buf_cnt;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_stream_reader.sv
// Directed testbench for sram_stream_reader with a behavioural 1-cycle SRAM.
module tb_sram_stream_reader;
  localparam int DW = 64;
  localparam int MW = 8;
  localparam int AW = 14;
  localparam int LW = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [LW-1:0] len = '0;
  logic [AW-1:0] step_v = 14'd1;
`ifdef SRAM_RD_STRIDE_EN
  logic [AW-1:0] stride = 14'd1;
`endif
  logic          busy, done, sram_cs, sram_we;
  logic [MW-1:0] sram_wem;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din;
  logic [DW-1:0] sram_dout = '0;
  logic          m_valid, m_last;
  logic [DW-1:0] m_data;
  logic          m_ready = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  sram_stream_reader #(.DW(DW), .MW(MW), .AW(AW), .LW(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
`ifdef SRAM_RD_STRIDE_EN
    .stride(stride),
`endif
    .busy(busy), .done(done), .sram_cs(sram_cs), .sram_we(sram_we),
    .sram_wem(sram_wem), .sram_addr(sram_addr), .sram_din(sram_din),
    .sram_dout(sram_dout), .m_valid(m_valid), .m_data(m_data),
    .m_last(m_last), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
    return {16'hBEEF, 2'b00, a, 2'b11, ~a, 16'h5A5A ^ {2'b00, a}};
  endfunction

  // Preloaded SRAM contents: every address holds word_of(address).
  always @(posedge clk) begin
    if (sram_cs) sram_dout <= word_of(sram_addr);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ":busy"}, 64'(busy), 64'd0);
    check({tag, ":done"}, 64'(done), 64'd0);
    check({tag, ":cs"}, 64'(sram_cs), 64'd0);
    check({tag, ":addr"}, 64'(sram_addr), 64'd0);
    check({tag, ":valid"}, 64'(m_valid), 64'd0);
    check({tag, ":data"}, m_data, 64'd0);
    check({tag, ":last"}, 64'(m_last), 64'd0);
  endtask

  // Runs one transfer. Start pulses in cycle 0; m_ready is low in cycles
  // stall_lo..stall_hi; a stray start is pulsed at busy_start_cyc.
  task automatic run_xfer(input string name, input logic [AW-1:0] base,
                          input logic [LW-1:0] n, input int stall_lo,
                          input int stall_hi, input int busy_start_cyc);
    logic [AW-1:0] addr_seen[$];
    logic [DW-1:0] data_seen[$];
    logic          last_seen[$];
    logic [DW-1:0] held;
    logic [AW-1:0] ea;
    bit hold_pending = 0, done_seen = 0, busy_seen = 0, done_busy = 0;
    int cyc, n_cs = 0, pops = 0, max_out = 0, hold_err = 0, cs_in_stall = 0;
    int first_cs = -1, last_cs = -1, first_valid = -1, first_beat = -1;
    int last_beat = -1, done_cyc = -1;
    @(posedge clk); #1;
    start = 1'b1; base_addr = base; len = n; m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (!done_seen && cyc < 300) begin
      m_ready = !(cyc >= stall_lo && cyc <= stall_hi);
      start = (cyc == busy_start_cyc);
      if (start) begin base_addr = 14'h2AAA; len = 15'd5; end
      @(negedge clk);
      if (sram_cs) begin
        addr_seen.push_back(sram_addr);
        n_cs++;
        if (first_cs < 0) first_cs = cyc;
        last_cs = cyc;
        if (cyc >= stall_lo && cyc <= stall_hi) cs_in_stall++;
      end
      if (hold_pending && (!m_valid || m_data !== held)) hold_err++;
      hold_pending = 0;
      if (m_valid && first_valid < 0) first_valid = cyc;
      if (m_valid && m_ready) begin
        data_seen.push_back(m_data);
        last_seen.push_back(m_last);
        if (first_beat < 0) first_beat = cyc;
        last_beat = cyc;
        pops++;
      end else if (m_valid) begin
        hold_pending = 1;
        held = m_data;
      end
      if (n_cs - pops > max_out) max_out = n_cs - pops;
      if (busy) busy_seen = 1;
      if (done) begin done_seen = 1; done_cyc = cyc; done_busy = busy; end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0; m_ready = 1'b1;
    check({name, ":done_seen"}, 64'(done_seen), 64'd1);
    if (n == 0) begin
      check({name, ":cs_count"}, 64'(n_cs), 64'd0);
      check({name, ":done_cyc"}, 64'(done_cyc), 64'd1);
      check({name, ":busy_seen"}, 64'(busy_seen), 64'd0);
    end else begin
      check({name, ":busy_seen"}, 64'(busy_seen), 64'd1);
      check({name, ":latency"}, 64'(first_valid), 64'd3);
      check({name, ":cs_count"}, 64'(n_cs), 64'(n));
      check({name, ":beats"}, 64'(pops), 64'(n));
      check({name, ":done_after_last"}, 64'(done_cyc), 64'(last_beat + 1));
      check({name, ":busy_at_done"}, 64'(done_busy), 64'd0);
      check({name, ":max_outstanding_le2"}, 64'(max_out <= 2), 64'd1);
      check({name, ":hold_stable"}, 64'(hold_err), 64'd0);
      if (stall_lo <= stall_hi) begin
        check({name, ":cs_in_stall"}, 64'(cs_in_stall), 64'd0);
      end else begin
        check({name, ":first_cs"}, 64'(first_cs), 64'd1);
        check({name, ":cs_contiguous"}, 64'(last_cs - first_cs), 64'(n - 1));
        check({name, ":beats_contiguous"}, 64'(last_beat - first_beat), 64'(n - 1));
      end
      for (int i = 0; i < int'(n) && i < addr_seen.size() && i < data_seen.size(); i++) begin
        ea = base + AW'(i) * step_v;
        check($sformatf("%s:addr%0d", name, i), 64'(addr_seen[i]), 64'(ea));
        check($sformatf("%s:data%0d", name, i), data_seen[i], word_of(ea));
        check($sformatf("%s:last%0d", name, i), 64'(last_seen[i]), 64'(i == int'(n) - 1));
      end
    end
  endtask

  initial begin
    int beats;
    int bad;
    #23;
    check_reset_outputs("reset");
    check("reset:we", 64'(sram_we), 64'd0);
    check("reset:wem", 64'(sram_wem), 64'd0);
    check("reset:din", sram_din, 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // Basic contiguous transfer, sink always ready.
    run_xfer("basic", 14'h0010, 15'd4, 0, -1, -1);
    // Backpressure in cycles 3-8.
    run_xfer("stall", 14'h0123, 15'd16, 3, 8, -1);
    // Address wrap at the top of the space.
    run_xfer("wrap", 14'h3FFE, 15'd4, 0, -1, -1);
    // Zero-length request.
    run_xfer("len0", 14'h0055, 15'd0, 0, -1, -1);

    // Reset during the third word of an 8-word transfer.
    @(posedge clk); #1;
    start = 1'b1; base_addr = 14'h0200; len = 15'd8; m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    beats = 0;
    for (int c = 0; c < 50 && beats < 3; c++) begin
      @(negedge clk);
      if (m_valid && m_ready) beats++;
      if (beats < 3) begin @(posedge clk); #1; end
    end
    check("abort:reached_word3", 64'(beats), 64'd3);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (done || sram_cs || busy || m_valid) bad++;
    end
    check("abort:quiet_after", 64'(bad), 64'd0);
    run_xfer("after_rst", 14'h0040, 15'd2, 0, -1, -1);

    // Stray start while busy must be ignored.
`ifdef SRAM_RD_STRIDE_EN
    stride = 14'd4; step_v = 14'd4;
`endif
    run_xfer("busy_start", 14'h0100, 15'd3, 0, -1, 2);
    @(negedge clk);
    check("busy_start:idle_after", 64'(busy), 64'd0);
    check("busy_start:no_cs_after", 64'(sram_cs), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
